mcu_banked: RTL and testbench
=============================

// Module: mcu_banked
// PURPOSE
//  Multi-bank local-memory control unit for the matrix processing unit. Holds NUM_BANKS chunk
//  registers of CHUNK_BITS each; the compute side reads/writes whole chunks in parallel, and the
//  host side streams one chunk at a time as HOST_BITS-wide beats (load from host, drain to host)
//  over valid/ready handshakes. Sits between the host byte interface and the MPU datapath.
// PARAMETERS
//  CHUNK_BITS  512  width of one bank/chunk; must be a multiple of HOST_BITS
//  HOST_BITS   8    host beat width
//  NUM_BANKS   4    number of chunk banks, >= 2; BANK_W = $clog2(NUM_BANKS); BEATS = CHUNK_BITS/HOST_BITS
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  rst            in   1           synchronous, active-high reset
//  chunk_wr_en    in   1           parallel write of chunk_in into bank chunk_wr_bank
//  chunk_wr_bank  in   BANK_W      parallel write bank select
//  chunk_in       in   CHUNK_BITS  parallel write data
//  chunk_rd_bank  in   BANK_W      parallel read bank select
//  chunk_out      out  CHUNK_BITS  registered bank contents, 1-cycle latency
//  host_cmd_valid in   1           start a host transfer
//  host_cmd_dir   in   1           0 = LOAD (host->bank), 1 = DRAIN (bank->host)
//  host_cmd_bank  in   BANK_W      target bank of transfer
//  host_cmd_ready out  1           high only in IDLE
//  host_in_valid  in   1           load beat valid
//  host_in_data   in   HOST_BITS   load beat data
//  host_in_ready  out  1           high only in LOAD
//  host_out_valid out  1           high only in DRAIN
//  host_out_data  out  HOST_BITS   drain beat data
//  host_out_ready in   1           host accepts drain beat
//  busy           out  1           high in LOAD, DRAIN, DONE
//  done_flag      out  1           one-cycle pulse in DONE after final beat
//  err_flag       out  1           (MCU_OVERRUN_FLAG_EN only) sticky conflict flag
//  err_clr        in   1           (MCU_OVERRUN_FLAG_EN only) clears err_flag
// BEHAVIOUR
//  - Reset: all banks, staging reg, beat counter, chunk_out := 0; state := IDLE; all ready/valid,
//    busy, done_flag, err_flag := 0. Reset mid-transfer aborts it; no bank commit occurs.
//  - FSM IDLE -> (cmd_valid & cmd_ready) -> LOAD or DRAIN; cmd bank/dir latched at accept.
//  - LOAD: each host_in_valid & host_in_ready writes beat b into staging[b*HOST_BITS +: HOST_BITS]
//    (beat 0 = LSBs), b++. On beat BEATS-1: staging with final beat commits to the latched bank
//    in that same edge; -> DONE. Unwritten stall cycles hold state.
//  - DRAIN: at cmd accept, staging := bank[cmd_bank]; host_out_valid high from next cycle;
//    host_out_data = staging[b*HOST_BITS +: HOST_BITS]; advance on valid & ready; after beat
//    BEATS-1 accepted -> DONE. Data stable while valid & !ready.
//  - DONE: done_flag = 1 for exactly one cycle, -> IDLE. Back-to-back cmd accepted next cycle.
//  - Counter wraps to 0 on entry to DONE; never exceeds BEATS-1.
//  - Parallel read: chunk_out <= bank[chunk_rd_bank] every cycle; same-cycle write to that bank
//    returns old data (read-before-write).
//  - Conflict: chunk_wr_en targeting the bank latched by an active LOAD or DRAIN is dropped
//    (bank unchanged); writes to other banks proceed normally during host transfers.
//  - Commit and parallel write to different banks on same edge: both take effect.
// CONFIGURATION
//  MCU_OVERRUN_FLAG_EN defined: err_flag/err_clr ports exist; err_flag sets on any dropped
//    conflicting chunk write or on host_in_valid/host_cmd_valid while corresponding ready is low
//    during busy; stays set until err_clr or rst (set wins over clr same cycle).
//  Not defined: ports absent; conflicting writes still dropped silently.
// STRUCTURE
//  Package mcu_pkg: state enum {IDLE, LOAD, DRAIN, DONE}; DIR_LOAD=1'b0, DIR_DRAIN=1'b1;
//    functions for BEATS and BANK_W from parameters.
//  Sub-module mcu_beat_serdes: staging register + beat counter + beat insert/select mux,
//    parameterised on CHUNK_BITS/HOST_BITS, with last_beat output to the FSM.
// TESTING
//  1 Reset then read all banks -> chunk_out == 0 one cycle after each chunk_rd_bank change.
//  2 Parallel write bank1 = {256{2'b01}}, bank2 = {256{2'b10}}, read back -> exact match, 1-cycle latency.
//  3 LOAD bank0 with beats 8'h01..8'h40, continuous valid -> done_flag pulse 65 cycles after
//    accept; bank0 byte k == k+1.
//  4 DRAIN bank0 with host_out_ready toggling 1010.. -> 64 beats 8'h01..8'h40 in order, data held
//    during stalls, single done_flag.
//  5 During LOAD of bank3, chunk_wr_en to bank3 and bank1 -> bank3 holds loaded data, bank1
//    updated; with MCU_OVERRUN_FLAG_EN err_flag = 1 until err_clr.
//  6 rst at beat 30 of LOAD into bank2 (preloaded 'hFF..) -> IDLE, bank2 == 0, no done_flag.

Source files
------------

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and sizing helpers for the banked MPU local-memory unit.
// Holds the transfer FSM state encoding, host transfer direction codes and
// constant functions that derive beat counts and select widths from parameters.
package mcu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mcu_state_e;

   localparam logic DIR_LOAD  = 1'b0;
   localparam logic DIR_DRAIN = 1'b1;

   // Number of host beats that make up one chunk.
   function automatic int calc_beats(input int chunk_bits, input int host_bits);
      return chunk_bits / host_bits;
   endfunction

   // Width of a bank select; at least one bit so ports never collapse.
   function automatic int calc_bank_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

   // Width of the beat counter; at least one bit.
   function automatic int calc_cnt_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/mcu_banked_if.sv
// mcu_banked_if: host-side command / load / drain handshakes of the banked
// local-memory unit. The host drives through the master modport, the memory
// unit answers through the slave modport.
interface mcu_banked_if
   import mcu_pkg::*;
#(
   parameter int HOST_BITS = 8,
   parameter int NUM_BANKS = 4
) ();

   localparam int BANK_W = calc_bank_w(NUM_BANKS);

   // transfer command
   logic                 host_cmd_valid;
   logic                 host_cmd_dir;
   logic [BANK_W-1:0]    host_cmd_bank;
   logic                 host_cmd_ready;

   // load beats (host -> bank)
   logic                 host_in_valid;
   logic [HOST_BITS-1:0] host_in_data;
   logic                 host_in_ready;

   // drain beats (bank -> host)
   logic                 host_out_valid;
   logic [HOST_BITS-1:0] host_out_data;
   logic                 host_out_ready;

   modport master (
      output host_cmd_valid, host_cmd_dir, host_cmd_bank,
      input  host_cmd_ready,
      output host_in_valid, host_in_data,
      input  host_in_ready,
      input  host_out_valid, host_out_data,
      output host_out_ready
   );

   modport slave (
      input  host_cmd_valid, host_cmd_dir, host_cmd_bank,
      output host_cmd_ready,
      input  host_in_valid, host_in_data,
      output host_in_ready,
      output host_out_valid, host_out_data,
      input  host_out_ready
   );

endinterface

// File: rtl/mcu_beat_serdes.sv
// mcu_beat_serdes: chunk-wide staging register plus beat counter. Loads insert
// one host beat per write at the counter position (beat 0 = LSBs); drains
// present the beat selected by the counter. The counter wraps to zero after the
// final beat so every transfer starts from beat 0.
module mcu_beat_serdes
   import mcu_pkg::*;
#(
   parameter  int CHUNK_BITS = 512,
   parameter  int HOST_BITS  = 8,
   localparam int BEATS      = calc_beats(CHUNK_BITS, HOST_BITS),
   localparam int CNT_W      = calc_cnt_w(BEATS)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  stage_load_i,   // copy a whole chunk into staging
   input  logic [CHUNK_BITS-1:0] stage_data_i,
   input  logic                  beat_wr_i,      // insert beat_i and advance
   input  logic                  beat_adv_i,     // advance without writing (drain)
   input  logic [HOST_BITS-1:0]  beat_i,
   output logic [HOST_BITS-1:0]  beat_o,         // beat selected by the counter
   output logic [CHUNK_BITS-1:0] chunk_ins_o,    // staging with beat_i inserted
   output logic                  last_beat_o
);

   logic [CHUNK_BITS-1:0] staging_q;
   logic [CNT_W-1:0]      cnt_q;

   // Insert mux: only the lane addressed by the counter takes the new beat.
   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_lane
         assign chunk_ins_o[gi*HOST_BITS +: HOST_BITS] =
            (cnt_q == CNT_W'(gi)) ? beat_i : staging_q[gi*HOST_BITS +: HOST_BITS];
      end
   endgenerate

   assign beat_o      = staging_q[cnt_q*HOST_BITS +: HOST_BITS];
   assign last_beat_o = (cnt_q == CNT_W'(BEATS - 1));

   // Beat counter: steps on every accepted beat, wraps after the last one.
   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= '0;
      end else if (beat_wr_i || beat_adv_i) begin
         cnt_q <= last_beat_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Staging register: whole-chunk snapshot for drains, beat assembly for loads.
   always_ff @(posedge clk) begin
      if (srst) begin
         staging_q <= '0;
      end else if (stage_load_i) begin
         staging_q <= stage_data_i;
      end else if (beat_wr_i) begin
         staging_q <= chunk_ins_o;
      end
   end

endmodule

// File: rtl/mcu_banked.sv
// mcu_banked: multi-bank local-memory control unit for the matrix processing
// unit. NUM_BANKS chunk registers are written/read in parallel by the compute
// side, while the host streams one chunk at a time as HOST_BITS beats (LOAD into
// a bank, DRAIN out of a bank). A compute write to the bank owned by an active
// host transfer is dropped. Optional feature macro MCU_OVERRUN_FLAG_EN adds a
// sticky err_flag (cleared by err_clr) for dropped writes and handshake misuse.
module mcu_banked
   import mcu_pkg::*;
#(
   parameter  int CHUNK_BITS = 512,
   parameter  int HOST_BITS  = 8,
   parameter  int NUM_BANKS  = 4,
   localparam int BANK_W     = calc_bank_w(NUM_BANKS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  chunk_wr_en,
   input  logic [BANK_W-1:0]     chunk_wr_bank,
   input  logic [CHUNK_BITS-1:0] chunk_in,
   input  logic [BANK_W-1:0]     chunk_rd_bank,
   output logic [CHUNK_BITS-1:0] chunk_out,
   mcu_banked_if.slave           host,
   output logic                  busy,
   output logic                  done_flag
`ifdef MCU_OVERRUN_FLAG_EN
   ,
   output logic                  err_flag,
   input  logic                  err_clr
`endif
);

   mcu_state_e            state_q;
   logic [BANK_W-1:0]     xfer_bank_q;
   logic                  cmd_ready_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic                  done_q;
   logic [CHUNK_BITS-1:0] chunk_out_q;

   logic [CHUNK_BITS-1:0] bank_rd [NUM_BANKS];
   logic [CHUNK_BITS-1:0] rd_sel;
   logic [CHUNK_BITS-1:0] stage_src;
   logic [CHUNK_BITS-1:0] chunk_ins;
   logic [HOST_BITS-1:0]  beat_out;
   logic                  last_beat;

   logic cmd_accept;
   logic drain_accept;
   logic load_beat;
   logic drain_beat;
   logic commit;
   logic xfer_active;
   logic conflict;
   logic par_we;

   assign cmd_accept   = host.host_cmd_valid & cmd_ready_q;
   assign drain_accept = cmd_accept & (host.host_cmd_dir == DIR_DRAIN);
   assign load_beat    = host.host_in_valid & in_ready_q;
   assign drain_beat   = out_valid_q & host.host_out_ready;
   assign commit       = load_beat & last_beat;

   // The latched bank belongs to the host only while beats are moving.
   assign xfer_active  = (state_q == LOAD) || (state_q == DRAIN);
   assign conflict     = chunk_wr_en & xfer_active & (chunk_wr_bank == xfer_bank_q);
   assign par_we       = chunk_wr_en & ~conflict;

   // Bank select muxes for the parallel read port and the drain snapshot.
   always_comb begin
      rd_sel    = '0;
      stage_src = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (chunk_rd_bank == BANK_W'(i)) rd_sel = bank_rd[i];
         if (host.host_cmd_bank == BANK_W'(i)) stage_src = bank_rd[i];
      end
   end

   mcu_beat_serdes #(
      .CHUNK_BITS (CHUNK_BITS),
      .HOST_BITS  (HOST_BITS)
   ) u_serdes (
      .clk          (clk),
      .srst         (rst),
      .stage_load_i (drain_accept),
      .stage_data_i (stage_src),
      .beat_wr_i    (load_beat),
      .beat_adv_i   (drain_beat),
      .beat_i       (host.host_in_data),
      .beat_o       (beat_out),
      .chunk_ins_o  (chunk_ins),
      .last_beat_o  (last_beat)
   );

   // Banks: host commit and compute write never hit the same bank on one edge
   // because a compute write to the transfer bank is a conflict and is dropped.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic [CHUNK_BITS-1:0] mem_q;
         logic                  commit_hit;
         logic                  wr_hit;

         assign commit_hit  = commit && (xfer_bank_q == BANK_W'(gi));
         assign wr_hit      = par_we && (chunk_wr_bank == BANK_W'(gi));
         assign bank_rd[gi] = mem_q;

         // One chunk register: final LOAD beat commit or parallel compute write.
         always_ff @(posedge clk) begin
            if (rst) begin
               mem_q <= '0;
            end else if (commit_hit) begin
               mem_q <= chunk_ins;
            end else if (wr_hit) begin
               mem_q <= chunk_in;
            end
         end
      end
   endgenerate

   // Parallel read port: registered, sees pre-write contents on a same-edge write.
   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_out_q <= '0;
      end else begin
         chunk_out_q <= rd_sel;
      end
   end

   // Transfer FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         xfer_bank_q <= '0;
         cmd_ready_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_accept) begin
                  xfer_bank_q <= host.host_cmd_bank;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (host.host_cmd_dir == DIR_LOAD) begin
                     state_q    <= LOAD;
                     in_ready_q <= 1'b1;
                  end else begin
                     state_q     <= DRAIN;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (commit) begin
                  state_q    <= DONE;
                  in_ready_q <= 1'b0;
                  done_q     <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_beat && last_beat) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b0;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

`ifdef MCU_OVERRUN_FLAG_EN
   logic err_q;
   logic err_set;

   assign err_set = conflict
                  | (busy_q & host.host_in_valid & ~in_ready_q)
                  | (busy_q & host.host_cmd_valid & ~cmd_ready_q);

   // Sticky error: a new event in the same cycle as err_clr keeps it set.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign err_flag = err_q;
`endif

   assign chunk_out           = chunk_out_q;
   assign busy                = busy_q;
   assign done_flag           = done_q;
   assign host.host_cmd_ready = cmd_ready_q;
   assign host.host_in_ready  = in_ready_q;
   assign host.host_out_valid = out_valid_q;
   assign host.host_out_data  = beat_out;

endmodule

// File: tb/tb_mcu_banked.sv
// tb_mcu_banked: directed + randomized bench for mcu_banked. Bank contents are
// tracked in a plain array of chunks; drained beats and read-back values are
// derived from that array with byte arithmetic.
module tb_mcu_banked;

   localparam int CB     = 512;
   localparam int HB     = 8;
   localparam int NB     = 4;
   localparam int BW     = 2;
   localparam int NBEATS = CB / HB;

   logic          clk = 1'b0;
   logic          rst;
   logic          chunk_wr_en;
   logic [BW-1:0] chunk_wr_bank;
   logic [CB-1:0] chunk_in;
   logic [BW-1:0] chunk_rd_bank;
   logic [CB-1:0] chunk_out;
   logic          busy;
   logic          done_flag;
`ifdef MCU_OVERRUN_FLAG_EN
   logic          err_flag;
   logic          err_clr;
`endif

   mcu_banked_if #(.HOST_BITS(HB), .NUM_BANKS(NB)) hif ();

   mcu_banked #(
      .CHUNK_BITS (CB),
      .HOST_BITS  (HB),
      .NUM_BANKS  (NB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .chunk_wr_en   (chunk_wr_en),
      .chunk_wr_bank (chunk_wr_bank),
      .chunk_in      (chunk_in),
      .chunk_rd_bank (chunk_rd_bank),
      .chunk_out     (chunk_out),
      .host          (hif.slave),
      .busy          (busy),
      .done_flag     (done_flag)
`ifdef MCU_OVERRUN_FLAG_EN
      ,
      .err_flag      (err_flag),
      .err_clr       (err_clr)
`endif
   );

   always #5 clk = ~clk;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [CB-1:0] model [NB];

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CB-1:0] rand_chunk();
      logic [CB-1:0] r;
      for (int w = 0; w < CB / 32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic start_cmd(input bit dir, input int bank);
      chk("cmd_ready_idle", hif.host_cmd_ready, 1);
      hif.host_cmd_valid = 1'b1;
      hif.host_cmd_dir   = dir;
      hif.host_cmd_bank  = BW'(bank);
      tick();
      hif.host_cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_busy", hif.host_cmd_ready, 0);
      chk("in_ready_after_accept", hif.host_in_ready, !dir);
      chk("out_valid_after_accept", hif.host_out_valid, dir);
   endtask

   // LOAD a chunk; optional random stalls, optional compute writes mid-transfer,
   // optional early stop after stop_after beats (leaves the transfer open).
   task automatic load_xfer(input int bank, input logic [CB-1:0] data, input bit gaps,
                            input bit conflict, input int stop_after);
      int ob;
      ob = (bank + 2) % NB;
      start_cmd(1'b0, bank);
      for (int k = 0; k < NBEATS; k++) begin
         if (k == stop_after) return;
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               hif.host_in_valid = 1'b0;
               tick();
               chk("load_stall_ready", hif.host_in_ready, 1);
               chk("load_stall_done", done_flag, 0);
            end
         end
         hif.host_in_valid = 1'b1;
         hif.host_in_data  = data[k*HB +: HB];
         if (conflict && k == 10) begin
            chunk_wr_en   = 1'b1;
            chunk_wr_bank = BW'(bank);
            chunk_in      = rand_chunk();
         end
         if (conflict && k == 20) begin
            chunk_wr_en   = 1'b1;
            chunk_wr_bank = BW'(ob);
            chunk_in      = rand_chunk();
         end
         tick();
         if (conflict && k == 20) model[ob] = chunk_in;
         chunk_wr_en       = 1'b0;
         hif.host_in_valid = 1'b0;
         if (k == NBEATS - 1) chk("load_done_pulse", done_flag, 1);
         else                 chk("load_done_early", done_flag, 0);
      end
      model[bank] = data;
      tick();
      chk("load_done_single", done_flag, 0);
      chk("load_back_idle_ready", hif.host_cmd_ready, 1);
      chk("load_back_idle_busy", busy, 0);
   endtask

   // DRAIN a bank; ready either toggles 1,0,1,0.. or is random.
   task automatic drain_xfer(input int bank, input bit rnd);
      logic [HB-1:0] exp_b;
      int            idx;
      int            cyc;
      bit            rdy;
      idx = 0;
      cyc = 0;
      start_cmd(1'b1, bank);
      while (idx < NBEATS && cyc < 1000) begin
         exp_b = model[bank][idx*HB +: HB];
         chk("drain_valid", hif.host_out_valid, 1);
         chk("drain_data", hif.host_out_data, exp_b);
         chk("drain_done_early", done_flag, 0);
         rdy = rnd ? bit'($urandom_range(0, 1)) : (cyc % 2 == 0);
         hif.host_out_ready = rdy;
         tick();
         if (rdy) idx++;
         cyc++;
      end
      hif.host_out_ready = 1'b0;
      chk("drain_beat_count", idx, NBEATS);
      chk("drain_done_pulse", done_flag, 1);
      chk("drain_valid_off", hif.host_out_valid, 0);
      tick();
      chk("drain_done_single", done_flag, 0);
      chk("drain_back_idle_ready", hif.host_cmd_ready, 1);
   endtask

   initial begin
      logic [CB-1:0] pat;
      logic [CB-1:0] exp_c;
      logic [CB-1:0] d;
      bit            we;
      int            wb;
      int            rb;

      rst                = 1'b1;
      chunk_wr_en        = 1'b0;
      chunk_wr_bank      = '0;
      chunk_in           = '0;
      chunk_rd_bank      = '0;
      hif.host_cmd_valid = 1'b0;
      hif.host_cmd_dir   = 1'b0;
      hif.host_cmd_bank  = '0;
      hif.host_in_valid  = 1'b0;
      hif.host_in_data   = '0;
      hif.host_out_ready = 1'b0;
`ifdef MCU_OVERRUN_FLAG_EN
      err_clr            = 1'b0;
`endif
      for (int b = 0; b < NB; b++) model[b] = '0;

      // reset state
      repeat (2) tick();
      chk("rst_chunk_out", chunk_out, 0);
      chk("rst_cmd_ready", hif.host_cmd_ready, 0);
      chk("rst_in_ready", hif.host_in_ready, 0);
      chk("rst_out_valid", hif.host_out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_flag, 0);
`ifdef MCU_OVERRUN_FLAG_EN
      chk("rst_err", err_flag, 0);
`endif
      rst = 1'b0;
      tick();
      chk("idle_cmd_ready", hif.host_cmd_ready, 1);

      // all banks read back zero
      for (int b = 0; b < NB; b++) begin
         chunk_rd_bank = BW'(b);
         tick();
         chk("rd_after_reset", chunk_out, model[b]);
      end

      // parallel writes, read-before-write on the same bank
      pat           = {256{2'b01}};
      chunk_wr_en   = 1'b1;
      chunk_wr_bank = 2'd1;
      chunk_in      = pat;
      chunk_rd_bank = 2'd1;
      tick();
      chk("rbw_old_data", chunk_out, model[1]);
      model[1]      = pat;
      pat           = {256{2'b10}};
      chunk_wr_bank = 2'd2;
      chunk_in      = pat;
      tick();
      chk("rd_bank1", chunk_out, model[1]);
      model[2]      = pat;
      chunk_wr_en   = 1'b0;
      chunk_rd_bank = 2'd2;
      tick();
      chk("rd_bank2", chunk_out, model[2]);

      // random parallel traffic while idle
      repeat (40) begin
         we            = bit'($urandom_range(0, 1));
         wb            = $urandom_range(0, NB - 1);
         rb            = $urandom_range(0, NB - 1);
         d             = rand_chunk();
         chunk_wr_en   = we;
         chunk_wr_bank = BW'(wb);
         chunk_in      = d;
         chunk_rd_bank = BW'(rb);
         exp_c         = model[rb];
         tick();
         chk("rand_rd", chunk_out, exp_c);
         if (we) model[wb] = d;
      end
      chunk_wr_en = 1'b0;

      // LOAD bank0 with bytes 1..64, continuous valid; then back-to-back DRAIN
      for (int k = 0; k < NBEATS; k++) pat[k*HB +: HB] = HB'(k + 1);
      load_xfer(0, pat, 1'b0, 1'b0, -1);
      drain_xfer(0, 1'b0);
      chunk_rd_bank = 2'd0;
      tick();
      chk("rd_bank0_loaded", chunk_out, pat);

`ifdef MCU_OVERRUN_FLAG_EN
      chk("err_clean_before_conflict", err_flag, 0);
`endif
      // LOAD bank3 with stalls and compute writes to bank3 (dropped) and bank1
      d = rand_chunk();
      load_xfer(3, d, 1'b1, 1'b1, -1);
      chunk_rd_bank = 2'd3;
      tick();
      chk("rd_bank3_after_conflict", chunk_out, model[3]);
      chunk_rd_bank = 2'd1;
      tick();
      chk("rd_bank1_side_write", chunk_out, model[1]);
`ifdef MCU_OVERRUN_FLAG_EN
      chk("err_set_by_conflict", err_flag, 1);
`endif
      drain_xfer(3, 1'b1);
`ifdef MCU_OVERRUN_FLAG_EN
      chk("err_sticky", err_flag, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", err_flag, 0);
`endif

      // reset mid-LOAD of preloaded bank2
      chunk_wr_en   = 1'b1;
      chunk_wr_bank = 2'd2;
      chunk_in      = '1;
      tick();
      chunk_wr_en   = 1'b0;
      model[2]      = '1;
      chunk_rd_bank = 2'd2;
      tick();
      chk("rd_bank2_preload", chunk_out, model[2]);
      load_xfer(2, rand_chunk(), 1'b0, 1'b0, 30);
      hif.host_in_valid = 1'b1;
      hif.host_in_data  = 8'hA5;
      rst               = 1'b1;
      tick();
      hif.host_in_valid = 1'b0;
      for (int b = 0; b < NB; b++) model[b] = '0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done_flag, 0);
      chk("abort_in_ready", hif.host_in_ready, 0);
      rst = 1'b0;
      tick();
      chk("abort_no_done", done_flag, 0);
      chk("abort_idle_ready", hif.host_cmd_ready, 1);
      for (int b = 0; b < NB; b++) begin
         chunk_rd_bank = BW'(b);
         tick();
         chk("rd_after_abort", chunk_out, model[b]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
